data_mem_access_unit: RTL and testbench

- Data-memory stage downstream of load_store_controller. Consumes its effective address, its store data (w_out/h_out/b_out), wr, and the b_e/h_e/w_e size strobes.
- Performs byte, half or word accesses on an internal word-wide synchronous RAM, little-endian.
- Splits accesses that straddle a word boundary into two RAM cycles.
- Returns load data right-justified and zero-extended; this is the mrdin input of load_store_controller, which does the sign extension.

---
 rtl/data_mem_access_unit_pkg.sv | 44 ++++
 rtl/data_mem_access_unit_if.sv | 27 ++
 rtl/data_mem_access_unit_data_ram_sp.sv | 27 ++
 rtl/data_mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit: FSM encoding,
// access-size byte masks and little-endian lane shifting.
package data_mem_access_unit_pkg;

   // RD_A is the read-issue cycle, which coincides with acceptance in IDLE.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      WR_B = 3'd3,
      RESP = 3'd4
   } state_t;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Place right-justified store data into its byte lanes across two words.
   function automatic logic [63:0] lane_shift(input logic [31:0] data,
                                              input logic [1:0]  off);
      return {32'b0, data} << {off, 3'b000};
   endfunction

   function automatic logic [7:0] be_shift(input logic [3:0] mask,
                                           input logic [1:0] off);
      return {4'b0, mask} << off;
   endfunction

   // Inverse of lane_shift: pull a right-justified value out of {hi, lo}.
   function automatic logic [31:0] lane_extract(input logic [31:0] hi,
                                                input logic [31:0] lo,
                                                input logic [1:0]  off);
      return 32'({hi, lo} >> {off, 3'b000});
   endfunction

   function automatic logic [31:0] bytes_to_bits(input logic [3:0] mask);
      logic [31:0] bits;
      for (int i = 0; i < 4; i++) begin
         bits[8*i +: 8] = {8{mask[i]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Request/response bus between the load/store controller and the
// data-memory access unit.
interface data_mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        wr;
   logic        b_e;
   logic        h_e;
   logic        w_e;
   logic [31:0] w_in;
   logic [15:0] h_in;
   logic [7:0]  b_in;
   logic [31:0] rd_data;
   logic        done;
   logic        err;

   modport master (
      output req_valid, addr, wr, b_e, h_e, w_e, w_in, h_in, b_in,
      input  req_ready, rd_data, done, err
   );

   modport slave (
      input  req_valid, addr, wr, b_e, h_e, w_e, w_in, h_in, b_in,
      output req_ready, rd_data, done, err
   );
endinterface

// File: rtl/data_mem_access_unit_data_ram_sp.sv
// Single-address word RAM: byte-enabled write and a registered read that
// returns the word at the current address one cycle later.
module data_ram_sp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   // NOTE: the array has no reset; clearing a RAM would need a sweep FSM
   // and would stop it mapping onto a block RAM.
   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_access_unit.sv
// Data-memory stage: byte/half/word little-endian accesses on a word RAM,
// splitting word-straddling accesses into two RAM cycles.
module data_mem_access_unit
   import data_mem_access_unit_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   data_mem_access_unit_if.slave  bus
);

   state_t        state;

   logic          accept;
   logic          one_hot;
   logic          range_err;
   logic          wrap_err;
   logic          req_err;
   logic          span;
   logic [2:0]    size_n;
   logic [3:0]    size_m;
   logic [1:0]    off;
   logic [AW-1:0] wa;
   logic [31:0]   store_data;
   logic [63:0]   shifted;
   logic [7:0]    be_lanes;

   logic [AW-1:0] wa_q;
   logic [1:0]    off_q;
   logic [3:0]    size_q;
   logic          span_q;
   logic [31:0]   hi_data_q;
   logic [3:0]    hi_be_q;
   logic [31:0]   a_word_q;

   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_q;
   logic [31:0]   load_result;

   assign bus.req_ready = (state == IDLE) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;

   // Request decode, evaluated on the live inputs during the accept cycle.
   assign one_hot    = ({bus.w_e, bus.h_e, bus.b_e} == 3'b001) ||
                       ({bus.w_e, bus.h_e, bus.b_e} == 3'b010) ||
                       ({bus.w_e, bus.h_e, bus.b_e} == 3'b100);
   assign size_m     = bus.w_e ? MASK_W : (bus.h_e ? MASK_H : MASK_B);
   assign size_n     = bus.w_e ? 3'd4 : (bus.h_e ? 3'd2 : 3'd1);
   assign off        = bus.addr[1:0];
   assign wa         = bus.addr[AW+1:2];
   assign span       = ({1'b0, off} + size_n) > 3'd4;
   assign range_err  = |bus.addr[31:AW+2];
   assign wrap_err   = span && (wa == AW'(DEPTH_WORDS - 1));
   assign req_err    = !one_hot || range_err || wrap_err;
   assign store_data = bus.w_e ? bus.w_in :
                       (bus.h_e ? {16'b0, bus.h_in} : {24'b0, bus.b_in});
   assign shifted    = lane_shift(store_data, off);
   assign be_lanes   = be_shift(size_m, off);

   // NOTE: every output of this block gets a default first so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      ram_addr  = wa;
      ram_be    = 4'b0000;
      ram_wdata = shifted[31:0];
      case (state)
         IDLE: begin
            if (accept && bus.wr && !req_err) begin
               ram_be = be_lanes[3:0];
            end
         end
         WR_B: begin
            ram_addr  = wa_q + AW'(1);
            ram_wdata = hi_data_q;
            // A reset landing here abandons the upper half of the store.
            if (!rst) begin
               ram_be = hi_be_q;
            end
         end
         RD_B:    ram_addr = wa_q + AW'(1);
         default: ram_addr = wa_q;
      endcase
   end

   // In RESP the RAM holds word A (aligned) or word B (spanning, A saved).
   assign load_result = lane_extract(span_q ? ram_q : 32'b0,
                                     span_q ? a_word_q : ram_q,
                                     off_q) & bytes_to_bits(size_q);

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
         bus.rd_data <= 32'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  wa_q      <= wa;
                  off_q     <= off;
                  size_q    <= size_m;
                  span_q    <= span;
                  hi_data_q <= shifted[63:32];
                  hi_be_q   <= be_lanes[7:4];
                  if (req_err) begin
                     bus.done    <= 1'b1;
                     bus.err     <= 1'b1;
                     bus.rd_data <= 32'b0;
                  end else if (bus.wr) begin
                     if (span) begin
                        state <= WR_B;
                     end else begin
                        bus.done    <= 1'b1;
                        bus.rd_data <= 32'b0;
                     end
                  end else begin
                     state <= span ? RD_B : RESP;
                  end
               end
            end
            WR_B: begin
               bus.done    <= 1'b1;
               bus.rd_data <= 32'b0;
               state       <= IDLE;
            end
            RD_B: begin
               a_word_q <= ram_q;
               state    <= RESP;
            end
            RESP: begin
               bus.done    <= 1'b1;
               bus.rd_data <= load_result;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   data_ram_sp #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit: a table of requests with
// hand-computed results, plus back-to-back and mid-operation reset sequences.
module tb_data_mem_access_unit;

   localparam int DEPTH_WORDS = 1024;
   localparam int AW          = 10;
   localparam logic [2:0] SB  = 3'b001;
   localparam logic [2:0] SH  = 3'b010;
   localparam logic [2:0] SW  = 3'b100;

   typedef struct {
      string       name;
      logic        wr;
      logic [2:0]  sel;      // {w_e, h_e, b_e}
      logic [31:0] addr;
      logic [31:0] data;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   vec_t vecs[$];

   data_mem_access_unit_if bus();

   data_mem_access_unit #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic wr,
                               input logic [2:0] sel, input logic [31:0] addr,
                               input logic [31:0] data, input logic exp_err,
                               input logic [31:0] exp_rd, input int exp_lat);
      vec_t v;
      v.name = name; v.wr = wr; v.sel = sel; v.addr = addr; v.data = data;
      v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
      return v;
   endfunction

   // Unselected data inputs carry inverted data so a wrong source shows up.
   task automatic drive(input logic wr, input logic [2:0] sel,
                        input logic [31:0] addr, input logic [31:0] data);
      bus.req_valid = 1'b1;
      bus.wr        = wr;
      {bus.w_e, bus.h_e, bus.b_e} = sel;
      bus.addr      = addr;
      bus.w_in      = sel[2] ? data : ~data;
      bus.h_in      = sel[1] ? data[15:0] : ~data[15:0];
      bus.b_in      = sel[0] ? data[7:0] : ~data[7:0];
   endtask

   // Called mid-cycle (at a falling edge); returns at the falling edge of
   // the cycle in which done is high, or after the latency bound.
   task automatic do_req(input vec_t v);
      int lat;
      int waited;
      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({v.name, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
      drive(v.wr, v.sel, v.addr, v.data);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = 99;
      check({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, "_err"}, {31'b0, bus.err}, {31'b0, v.exp_err});
      if (!v.exp_err) begin
         check({v.name, "_rd"}, bus.rd_data, v.exp_rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic done_seen;

      bus.req_valid = 1'b0;
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      bus.req_valid = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("reset_done", {31'b0, bus.done}, 32'd0);
      check("reset_err", {31'b0, bus.err}, 32'd0);
      check("reset_rd", bus.rd_data, 32'd0);
      check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

      // Table: applied in order, later loads observe earlier stores.
      vecs.push_back(mk("st_w10",     1, SW, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1));
      vecs.push_back(mk("ld_w10",     0, SW, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2));
      vecs.push_back(mk("st_w10b",    1, SW, 32'h10, 32'h11223344, 0, 32'h0, 1));
      vecs.push_back(mk("st_b13",     1, SB, 32'h13, 32'h000000A5, 0, 32'h0, 1));
      vecs.push_back(mk("ld_w10_lane",0, SW, 32'h10, 32'h0, 0, 32'hA5223344, 2));
      vecs.push_back(mk("ld_b13",     0, SB, 32'h13, 32'h0, 0, 32'h000000A5, 2));
      vecs.push_back(mk("ld_h12",     0, SH, 32'h12, 32'h0, 0, 32'h0000A522, 2));
      vecs.push_back(mk("zero_w20",   1, SW, 32'h20, 32'h0, 0, 32'h0, 1));
      vecs.push_back(mk("zero_w24",   1, SW, 32'h24, 32'h0, 0, 32'h0, 1));
      vecs.push_back(mk("st_h23",     1, SH, 32'h23, 32'h0000BEEF, 0, 32'h0, 2));
      vecs.push_back(mk("ld_w20",     0, SW, 32'h20, 32'h0, 0, 32'hEF000000, 2));
      vecs.push_back(mk("ld_w24",     0, SW, 32'h24, 32'h0, 0, 32'h000000BE, 2));
      vecs.push_back(mk("ld_h23",     0, SH, 32'h23, 32'h0, 0, 32'h0000BEEF, 3));
      vecs.push_back(mk("err_bh",     1, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1));
      vecs.push_back(mk("err_none",   0, 3'b000, 32'h10, 32'h0, 1, 32'h0, 1));
      vecs.push_back(mk("ld_w10_keep",0, SW, 32'h10, 32'h0, 0, 32'hA5223344, 2));
      vecs.push_back(mk("st_w00",     1, SW, 32'h00, 32'h13579BDF, 0, 32'h0, 1));
      vecs.push_back(mk("err_range",  1, SW, 32'hFFFF0000, 32'hFFFFFFFF, 1, 32'h0, 1));
      vecs.push_back(mk("ld_w00_keep",0, SW, 32'h00, 32'h0, 0, 32'h13579BDF, 2));
      vecs.push_back(mk("st_w_last",  1, SW, 32'hFFC, 32'h55667788, 0, 32'h0, 1));
      vecs.push_back(mk("err_wrap",   1, SW, 32'hFFE, 32'h99999999, 1, 32'h0, 1));
      vecs.push_back(mk("ld_w_last",  0, SW, 32'hFFC, 32'h0, 0, 32'h55667788, 2));
      vecs.push_back(mk("ld_h_last",  0, SH, 32'hFFE, 32'h0, 0, 32'h00005566, 2));
      vecs.push_back(mk("st_w30",     1, SW, 32'h30, 32'h03020100, 0, 32'h0, 1));
      vecs.push_back(mk("st_w34",     1, SW, 32'h34, 32'h07060504, 0, 32'h0, 1));
      vecs.push_back(mk("ld_w31",     0, SW, 32'h31, 32'h0, 0, 32'h04030201, 3));
      vecs.push_back(mk("ld_h33",     0, SH, 32'h33, 32'h0, 0, 32'h00000403, 3));
      vecs.push_back(mk("ld_b37",     0, SB, 32'h37, 32'h0, 0, 32'h00000007, 2));
      vecs.push_back(mk("st_w38",     1, SW, 32'h38, 32'h11111111, 0, 32'h0, 1));
      vecs.push_back(mk("st_w3c",     1, SW, 32'h3C, 32'h22222222, 0, 32'h0, 1));
      vecs.push_back(mk("st_w3a",     1, SW, 32'h3A, 32'hAABBCCDD, 0, 32'h0, 2));
      vecs.push_back(mk("ld_w38",     0, SW, 32'h38, 32'h0, 0, 32'hCCDD1111, 2));
      vecs.push_back(mk("ld_w3c",     0, SW, 32'h3C, 32'h0, 0, 32'h2222AABB, 2));
      vecs.push_back(mk("ld_w3a",     0, SW, 32'h3A, 32'h0, 0, 32'hAABBCCDD, 3));

      foreach (vecs[i]) begin
         do_req(vecs[i]);
      end

      // Back-to-back: valid held high; each store completes while the next
      // one is being accepted.
      drive(1'b1, SW, 32'h40, 32'hC0FFEE01);
      @(posedge clk);
      @(negedge clk);
      check("b2b_done1", {31'b0, bus.done}, 32'd1);
      check("b2b_ready1", {31'b0, bus.req_ready}, 32'd1);
      drive(1'b1, SW, 32'h40, 32'hC0FFEE02);
      @(posedge clk);
      @(negedge clk);
      check("b2b_done2", {31'b0, bus.done}, 32'd1);
      drive(1'b1, SW, 32'h40, 32'hC0FFEE03);
      @(posedge clk);
      @(negedge clk);
      check("b2b_done3", {31'b0, bus.done}, 32'd1);
      check("b2b_ready3", {31'b0, bus.req_ready}, 32'd1);
      drive(1'b0, SW, 32'h40, 32'h0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("b2b_ld_wait", {31'b0, bus.done}, 32'd0);
      @(negedge clk);
      check("b2b_ld_done", {31'b0, bus.done}, 32'd1);
      check("b2b_ld_rd", bus.rd_data, 32'hC0FFEE03);

      // Reset during the second half of a spanning word store at 0x0E.
      do_req(mk("pre_w0c", 1, SW, 32'h0C, 32'h11111111, 0, 32'h0, 1));
      do_req(mk("pre_w10", 1, SW, 32'h10, 32'h22222222, 0, 32'h0, 1));
      drive(1'b1, SW, 32'h0E, 32'hAABBCCDD);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_done_t1", {31'b0, bus.done}, 32'd0);
      check("rstmid_ready_in_rst", {31'b0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rstmid_ready_after", {31'b0, bus.req_ready}, 32'd1);
      done_seen = bus.done;
      repeat (3) begin
         @(negedge clk);
         done_seen = done_seen | bus.done;
      end
      check("rstmid_no_done", {31'b0, done_seen}, 32'd0);
      do_req(mk("rstmid_w0c", 0, SW, 32'h0C, 32'h0, 0, 32'hCCDD1111, 2));
      do_req(mk("rstmid_w10", 0, SW, 32'h10, 32'h0, 0, 32'h22222222, 2));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
